mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage of the 5-stage pipeline, paired with its MEM/WB pipeline register. It sits between EX/MEM and the write-back stage and produces the `MEM_R_EN`, `memData` and `aluRes` values the write-back mux selects from. It models a slow single-port data memory with a fixed number of wait states. While an access is in progress it asserts `freeze` to stall the upstream pipeline and inserts bubbles downstream.

## Interface
- `WORD_LEN`, 32 (from `defines.v`), data/address width
- `DEPTH`, 64, data memory size in words
- `WAIT_CYCLES`, 3, extra cycles a memory access spends in BUSY (0 legal)
- `ADDR_BASE`, 1024, byte address mapped to memory word 0

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-low reset
- `WB_EN_in`  in  1  instruction writes register file
- `MEM_R_EN_in`  in  1  load
- `MEM_W_EN_in`  in  1  store
- `aluRes_in`  in  WORD_LEN  ALU result / byte address
- `valRm_in`  in  WORD_LEN  store data
- `dest_in`  in  4  destination register
- `freeze`  out  1  stall request to IF/ID/EX and EX/MEM registers
- `WB_EN`  out  1  registered (MEM/WB)
- `MEM_R_EN`  out  1  registered
- `memData`  out  WORD_LEN  registered load data
- `aluRes`  out  WORD_LEN  registered
- `dest`  out  4  registered

## Operation
- Memory request: `req = MEM_R_EN_in | MEM_W_EN_in`.
- Word index: `(aluRes - ADDR_BASE) >> 2`, truncated to log2(DEPTH) bits. Low two address bits are ignored. Out-of-range addresses alias modulo DEPTH.
- FSM states:
  - IDLE with `req`: capture all `*_in` into holding registers. Go to BUSY with counter = 0, or go straight to DONE if `WAIT_CYCLES == 0`.
  - BUSY: counter increments each cycle. Go to DONE when counter == `WAIT_CYCLES-1`.
  - DONE: perform the access, load the MEM/WB register, return to IDLE.
- All access uses the captured values. Input changes while the FSM is not in IDLE are ignored.
- `freeze = rst & ((state==IDLE & req) | state==BUSY)`. This is combinational and is 0 in DONE.
- Store: the memory is written exactly once, on the DONE edge.
- Load: read is asynchronous. `memData` ← `mem[idx]` on the DONE edge.
- Load and store both asserted: the store wins and `memData` ← stored value. `MEM_R_EN` output follows the captured input.
- Non-memory instruction in IDLE: MEM/WB loads the inputs directly on the next edge. `memData` ← 0. No freeze.
- Freeze cycles: MEM/WB loads a bubble (`WB_EN=0`, `MEM_R_EN=0`). `memData`, `aluRes` and `dest` hold their values.

## Timing
- Reset (`rst` = 0 at an edge): state = IDLE, counter = 0, all MEM/WB outputs = 0, `freeze` = 0 combinationally.
  - Memory contents are not reset.
  - Reset during BUSY aborts the access and no write occurs.
- Non-memory latency: 1 cycle to MEM/WB.
- Memory access latency: `freeze` is high for exactly `WAIT_CYCLES+1` cycles. Result is in MEM/WB at the end of cycle `WAIT_CYCLES+2`.
- Upstream contract: registers hold while `freeze`=1. On the cycle after DONE, the next instruction is presented. Back-to-back memory accesses are fully serialised with no overlap.
- `rst` dominates all other inputs.

## Structure
- `defines.v` holds:
  - `WORD_LEN`
  - `REG_FILE_ADDR_LEN` (4)
  - state encodings `MEM_IDLE`, `MEM_BUSY`, `MEM_DONE`
- Sub-module `data_memory`: DEPTH×WORD_LEN, synchronous write with enable, asynchronous read.
- FSM, counter, holding registers and MEM/WB register live in `mem_access_stage`.

## Test plan
- Non-memory op: `aluRes_in`=0x55, `WB_EN_in`=1, `dest_in`=3 → next edge `WB_EN`=1, `aluRes`=0x55, `dest`=3, `memData`=0; `freeze` never high.
- Store then load, W=3:
  - Store 0xDEADBEEF to 1028 → `freeze` high 4 cycles, then MEM/WB `WB_EN`=0.
  - Load from 1028 → after 5 cycles `MEM_R_EN`=1, `memData`=0xDEADBEEF.
- Bubble check: during a load's freeze cycles `WB_EN` and `MEM_R_EN` outputs are 0. `aluRes` and `dest` keep their previous values.
- Aliasing: store 0x1234 to 1024+4·DEPTH, then load 1024 → `memData`=0x1234.
- Input ignored mid-access: change `aluRes_in` during BUSY → access uses the captured address.
- Reset mid-access: assert `rst`=0 in the second BUSY cycle of a store to 1032 → outputs 0, `freeze` 0; a later load of 1032 returns the old value.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared widths, FSM state encoding and record types for the memory-access stage
// and its MEM/WB register.
package mem_access_stage_pkg;

  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic                         wb_en;
    logic                         mem_r_en;
    logic                         mem_w_en;
    logic [WORD_LEN-1:0]          alu_res;
    logic [WORD_LEN-1:0]          val_rm;
    logic [REG_FILE_ADDR_LEN-1:0] dest;
  } mem_instr_t;

  typedef struct packed {
    logic                         wb_en;
    logic                         mem_r_en;
    logic [WORD_LEN-1:0]          mem_data;
    logic [WORD_LEN-1:0]          alu_res;
    logic [REG_FILE_ADDR_LEN-1:0] dest;
  } mem_wb_t;

  // Word offset of a byte address from the memory base; callers truncate to the index width.
  function automatic logic [WORD_LEN-1:0] word_offset(input logic [WORD_LEN-1:0] addr,
                                                      input logic [WORD_LEN-1:0] base);
    return (addr - base) >> 32'd2;
  endfunction

endpackage

// File: rtl/mem_access_stage_data_memory.sv
// Single-port data memory: synchronous write with enable, asynchronous read.
// Contents are deliberately not reset.
module data_memory #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage with MEM/WB register: captures a memory instruction, stalls
// upstream for a fixed number of wait states, then performs the access once.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_BASE   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         WB_EN_in,
  input  logic                         MEM_R_EN_in,
  input  logic                         MEM_W_EN_in,
  input  logic [WORD_LEN-1:0]          aluRes_in,
  input  logic [WORD_LEN-1:0]          valRm_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
  output logic                         freeze,
  output logic                         WB_EN,
  output logic                         MEM_R_EN,
  output logic [WORD_LEN-1:0]          memData,
  output logic [WORD_LEN-1:0]          aluRes,
  output logic [REG_FILE_ADDR_LEN-1:0] dest
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);

  mem_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  mem_instr_t          hold_q, hold_d;
  mem_wb_t             mw_q, mw_d;
  logic                req_s;
  logic                mem_we_s;
  logic [IDX_W-1:0]    mem_idx_s;
  logic [WORD_LEN-1:0] rdata_s;

  assign req_s     = MEM_R_EN_in | MEM_W_EN_in;
  assign mem_idx_s = IDX_W'(word_offset(hold_q.alu_res, WORD_LEN'(ADDR_BASE)));

  data_memory #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_LEN),
    .IDX_W (IDX_W)
  ) u_dmem (
    .clk_i   (clk),
    .we_i    (mem_we_s),
    .addr_i  (mem_idx_s),
    .wdata_i (hold_q.val_rm),
    .rdata_o (rdata_s)
  );

  // State and wait-counter register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MEM_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (req_s) begin
          state_d = (WAIT_CYCLES == 0) ? MEM_DONE : MEM_BUSY;
        end else begin
          state_d = MEM_IDLE;
        end
      end
      MEM_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          state_d = MEM_DONE;
        end else begin
          state_d = MEM_BUSY;
        end
      end
      MEM_DONE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = MEM_IDLE;
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = MEM_IDLE;
      end
    endcase
  end

  // FSM outputs; the write is gated by reset so an access aborted in DONE never lands.
  always_comb begin
    freeze   = rst & (((state_q == MEM_IDLE) & req_s) | (state_q == MEM_BUSY));
    mem_we_s = rst & (state_q == MEM_DONE) & hold_q.mem_w_en;
  end

  // Holding register captures the instruction only when an access starts.
  always_comb begin
    if ((state_q == MEM_IDLE) && req_s) begin
      hold_d = '{wb_en: WB_EN_in, mem_r_en: MEM_R_EN_in, mem_w_en: MEM_W_EN_in,
                 alu_res: aluRes_in, val_rm: valRm_in, dest: dest_in};
    end else begin
      hold_d = hold_q;
    end
  end

  // MEM/WB next value: pass-through, bubble while frozen, or completed access.
  always_comb begin
    mw_d = mw_q;
    case (state_q)
      MEM_IDLE: begin
        if (req_s) begin
          mw_d.wb_en    = 1'b0;
          mw_d.mem_r_en = 1'b0;
        end else begin
          mw_d = '{wb_en: WB_EN_in, mem_r_en: MEM_R_EN_in, mem_data: {WORD_LEN{1'b0}},
                   alu_res: aluRes_in, dest: dest_in};
        end
      end
      MEM_BUSY: begin
        mw_d.wb_en    = 1'b0;
        mw_d.mem_r_en = 1'b0;
      end
      MEM_DONE: begin
        mw_d = '{wb_en: hold_q.wb_en, mem_r_en: hold_q.mem_r_en,
                 mem_data: hold_q.mem_w_en ? hold_q.val_rm : rdata_s,
                 alu_res: hold_q.alu_res, dest: hold_q.dest};
      end
      default: begin
        mw_d.wb_en    = 1'b0;
        mw_d.mem_r_en = 1'b0;
      end
    endcase
  end

  // Holding and MEM/WB registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q <= '0;
      mw_q   <= '0;
    end else begin
      hold_q <= hold_d;
      mw_q   <= mw_d;
    end
  end

  assign WB_EN    = mw_q.wb_en;
  assign MEM_R_EN = mw_q.mem_r_en;
  assign memData  = mw_q.mem_data;
  assign aluRes   = mw_q.alu_res;
  assign dest     = mw_q.dest;

endmodule
